// File: rtl/aes_128_round_ctrl.sv
// AES-128 round controller: sequences INIT, NR rounds of SB_LAT+1 cycles
// and a one-cycle DONE pulse for a shared-subbytes iterative datapath.
// Ports: clk, kill (async active-high reset), start, [abort],
//   busy, done, init_load, sb_load, st_load, key_step, last_round,
//   round[3:0], phase[2:0]. All outputs are registered.
// Optional: define AES_ROUND_CTRL_ABORT_EN to add the abort input.
module aes_128_round_ctrl #(
  parameter int NR     = 10,
  parameter int SB_LAT = 2
) (
  input  logic       clk,
  input  logic       kill,
  input  logic       start,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       done,
  output logic       init_load,
  output logic       sb_load,
  output logic       st_load,
  output logic       key_step,
  output logic       last_round,
  output logic [3:0] round,
  output logic [2:0] phase
);

  localparam logic [3:0] NR_L = 4'(NR);
  localparam logic [2:0] PH_L = 3'(SB_LAT);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    ROUND,
    DONE
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] round_nx;
  logic [2:0] phase_nx;
  logic       abort_hit;

`ifdef AES_ROUND_CTRL_ABORT_EN
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // round/phase registers double as the round/phase outputs, so
  // they are forced to 0 whenever the next state is not ROUND.
  always_comb begin
    state_nx = state;
    round_nx = round;
    phase_nx = phase;
    unique case (state)
      IDLE: begin
        round_nx = 4'd0;
        phase_nx = 3'd0;
        if (start) state_nx = INIT;
      end
      INIT: begin
        state_nx = ROUND;
        round_nx = 4'd1;
        phase_nx = 3'd0;
      end
      ROUND: begin
        if (phase == PH_L) begin
          phase_nx = 3'd0;
          if (round == NR_L) begin
            state_nx = DONE;
            round_nx = 4'd0;
          end else begin
            round_nx = round + 4'd1;
          end
        end else begin
          phase_nx = phase + 3'd1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        round_nx = 4'd0;
        phase_nx = 3'd0;
      end
      default: begin
        state_nx = IDLE;
        round_nx = 4'd0;
        phase_nx = 3'd0;
      end
    endcase
    if (abort_hit) begin
      state_nx = IDLE;
      round_nx = 4'd0;
      phase_nx = 3'd0;
    end
  end

  // Outputs are decoded from the next state and registered, so
  // each strobe lines up with the cycle its state is occupied.
  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      state      <= IDLE;
      round      <= 4'd0;
      phase      <= 3'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      init_load  <= 1'b0;
      sb_load    <= 1'b0;
      st_load    <= 1'b0;
      key_step   <= 1'b0;
      last_round <= 1'b0;
    end else begin
      state      <= state_nx;
      round      <= round_nx;
      phase      <= phase_nx;
      busy       <= (state_nx != IDLE);
      done       <= (state_nx == DONE);
      init_load  <= (state_nx == INIT);
      sb_load    <= (state_nx == ROUND) && (phase_nx == 3'd0);
      st_load    <= (state_nx == ROUND) && (phase_nx == PH_L);
      key_step   <= (state_nx == ROUND) && (phase_nx == PH_L);
      last_round <= (state_nx == ROUND) && (round_nx == NR_L);
    end
  end

endmodule

// File: tb/tb_aes_128_round_ctrl.sv
// Testbench for aes_128_round_ctrl: scoreboarded done timing plus
// a cycle-by-cycle reference model of every output.
module tb_aes_128_round_ctrl;

  localparam int NR     = 10;
  localparam int SB_LAT = 2;
  localparam int LAT    = 2 + NR * (SB_LAT + 1);
  localparam int PER    = LAT + 1;

  logic       clk = 1'b0;
  logic       kill;
  logic       start;
`ifdef AES_ROUND_CTRL_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       busy;
  logic       done;
  logic       init_load;
  logic       sb_load;
  logic       st_load;
  logic       key_step;
  logic       last_round;
  logic [3:0] round;
  logic [2:0] phase;
  logic [13:0] outv;

  int cyc = 0;
  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_128_round_ctrl #(
    .NR     (NR),
    .SB_LAT (SB_LAT)
  ) dut (
    .clk        (clk),
    .kill       (kill),
    .start      (start),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .busy       (busy),
    .done       (done),
    .init_load  (init_load),
    .sb_load    (sb_load),
    .st_load    (st_load),
    .key_step   (key_step),
    .last_round (last_round),
    .round      (round),
    .phase      (phase)
  );

  assign outv = {busy, done, init_load, sb_load, st_load,
                 key_step, last_round, round, phase};

  // Expected outputs rel cycles after the IDLE cycle that took start.
  function automatic logic [13:0] model(int rel);
    logic [13:0] v;
    int r;
    int p;
    v = '0;
    if (rel == 1) begin
      v[13] = 1'b1;
      v[11] = 1'b1;
    end else if (rel >= 2 && rel <= LAT - 1) begin
      r = (rel - 2) / (SB_LAT + 1) + 1;
      p = (rel - 2) % (SB_LAT + 1);
      v[13]  = 1'b1;
      v[10]  = (p == 0);
      v[9]   = (p == SB_LAT);
      v[8]   = (p == SB_LAT);
      v[7]   = (r == NR);
      v[6:3] = 4'(r);
      v[2:0] = 3'(p);
    end else if (rel == LAT) begin
      v[13] = 1'b1;
      v[12] = 1'b1;
    end
    return v;
  endfunction

  task automatic test_reset();
    kill  = 1'b1;
    start = 1'b0;
    #50;
    total_cnt++;
    if (outv !== 14'd0)
      $display("FAIL reset_hold out=%h exp=%h", outv, 14'd0);
    else pass_cnt++;
    kill = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total_cnt++;
      if (outv !== 14'd0)
        $display("FAIL reset_idle[%0d] out=%h exp=%h", i, outv, 14'd0);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    int t0;
    int rel;
    int st_cnt;
    int e;
    st_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + LAT);
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      rel = cyc - t0;
      total_cnt++;
      if (outv !== model(rel))
        $display("FAIL single rel=%0d out=%h exp=%h", rel, outv, model(rel));
      else pass_cnt++;
      if (st_load) st_cnt++;
      if (done) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL single_done unexpected at cyc=%0d exp=none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e)
            $display("FAIL single_done cyc=%0d exp=%0d", cyc, e);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (st_cnt !== NR)
      $display("FAIL single_st_count got=%0d exp=%0d", st_cnt, NR);
    else pass_cnt++;
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL single_missing_done left=%0d exp=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int t0;
    int rel;
    int e;
    logic [13:0] ev;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    for (int k = 0; k < 3; k++) exp_q.push_back(t0 + LAT + k * PER);
    for (int i = 0; i < 3 * PER + 6; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      if (rel == 2 * PER + 5) start = 1'b0;
      ev = (rel < 3 * PER) ? model(rel % PER) : 14'd0;
      total_cnt++;
      if (outv !== ev)
        $display("FAIL b2b rel=%0d out=%h exp=%h", rel, outv, ev);
      else pass_cnt++;
      if (done) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_done unexpected at cyc=%0d exp=none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e)
            $display("FAIL b2b_done cyc=%0d exp=%0d", cyc, e);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL b2b_missing_done left=%0d exp=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_start_ignored();
    int t0;
    int rel;
    int e;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + LAT);
    for (int i = 0; i < LAT + 6; i++) begin
      @(negedge clk);
      rel = cyc - t0;
      start = (rel == 2 + 4 * (SB_LAT + 1));
      total_cnt++;
      if (outv !== model(rel))
        $display("FAIL ignore rel=%0d out=%h exp=%h", rel, outv, model(rel));
      else pass_cnt++;
      if (done) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL ignore_done unexpected at cyc=%0d exp=none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e)
            $display("FAIL ignore_done cyc=%0d exp=%0d", cyc, e);
          else pass_cnt++;
        end
      end
    end
    start = 1'b0;
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL ignore_missing_done left=%0d exp=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  task automatic test_kill_mid();
    int t0;
    int rel;
    int e;
    int kill_rel;
    kill_rel = 2 + 3 * (SB_LAT + 1) + 1;
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + LAT);
    for (int i = 0; i < kill_rel; i++) begin
      @(negedge clk);
      start = 1'b0;
      rel = cyc - t0;
      total_cnt++;
      if (outv !== model(rel))
        $display("FAIL kill_pre rel=%0d out=%h exp=%h", rel, outv, model(rel));
      else pass_cnt++;
    end
    #2 kill = 1'b1;
    exp_q.delete();
    #1;
    total_cnt++;
    if (outv !== 14'd0)
      $display("FAIL kill_async out=%h exp=%h", outv, 14'd0);
    else pass_cnt++;
    @(negedge clk);
    kill = 1'b0;
    for (int i = 0; i < LAT + 8; i++) begin
      @(negedge clk);
      total_cnt++;
      if (outv !== 14'd0 || done !== 1'b0)
        $display("FAIL kill_idle[%0d] out=%h exp=%h", i, outv, 14'd0);
      else pass_cnt++;
    end
    @(negedge clk);
    start = 1'b1;
    t0 = cyc;
    exp_q.push_back(t0 + LAT);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      rel = cyc - t0;
      total_cnt++;
      if (outv !== model(rel))
        $display("FAIL kill_rerun rel=%0d out=%h exp=%h", rel, outv, model(rel));
      else pass_cnt++;
      if (done) begin
        total_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL kill_done unexpected at cyc=%0d exp=none", cyc);
        end else begin
          e = exp_q.pop_front();
          if (cyc !== e)
            $display("FAIL kill_done cyc=%0d exp=%0d", cyc, e);
          else pass_cnt++;
        end
      end
    end
    total_cnt++;
    if (exp_q.size() !== 0)
      $display("FAIL kill_missing_done left=%0d exp=0", exp_q.size());
    else pass_cnt++;
    exp_q.delete();
  endtask

  initial begin
    kill  = 1'b1;
    start = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_start_ignored();
    test_kill_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
